// File: rtl/serial_add_pkg.sv
// Shared types and sizing helpers for the bit-serial adder sequencer.
// Combinational definitions only: no latency, no flow control.
// Backpressure: not applicable.
package serial_add_pkg;

    typedef enum logic [1:0] {
        IDLE_S = 2'd0,
        BUSY_S = 2'd1,
        DONE_S = 2'd2
    } state_e;

    localparam int max_width_lp = 32;

    // The bit counter must still exist when the operand is a single bit.
    function automatic int cnt_width(input int width);
        return (width <= 1) ? 1 : $clog2(width);
    endfunction

endpackage

// File: rtl/full_add.sv
// Full adder cell built from two half adders and an OR of their carries.
// Latency: combinational.
// Backpressure: none.
module full_add (
    input  logic a_i,
    input  logic b_i,
    input  logic c_i,
    output logic s_o,
    output logic c_o
);

    logic s0;
    logic c0;
    logic c1;

    half_add u_ha0 (
        .a_i (a_i),
        .b_i (b_i),
        .s_o (s0),
        .c_o (c0)
    );

    half_add u_ha1 (
        .a_i (s0),
        .b_i (c_i),
        .s_o (s_o),
        .c_o (c1)
    );

    assign c_o = c0 | c1;

endmodule

// File: rtl/half_add.sv
// Half adder: sum and carry of two bits.
// Latency: combinational.
// Backpressure: none.
module half_add (
    input  logic a_i,
    input  logic b_i,
    output logic s_o,
    output logic c_o
);

    assign s_o = a_i ^ b_i;
    assign c_o = a_i & b_i;

endmodule

// File: rtl/serial_add_ctrl.sv
// Bit-serial adder: one full_add cell reused LSB-first over width_p cycles; SERIAL_ADD_OVERFLOW_EN adds overflow_o.
// Latency: result valid width_p+1 cycles after accept; one operation per width_p+2 cycles at best.
// Backpressure: DONE holds the result until ready_i; operands offered while busy are dropped, not queued.
module serial_add_ctrl
    import serial_add_pkg::*;
#(
    parameter int width_p = 8
) (
    input  logic               clk_i,
    input  logic               reset_i,
    input  logic               valid_i,
    output logic               ready_o,
    input  logic [width_p-1:0] a_i,
    input  logic [width_p-1:0] b_i,
    output logic               valid_o,
    input  logic               ready_i,
    output logic [width_p-1:0] sum_o,
`ifdef SERIAL_ADD_OVERFLOW_EN
    output logic               overflow_o,
`endif
    output logic               carry_o
);

    localparam int cnt_w_lp = cnt_width(width_p);
    localparam logic [cnt_w_lp-1:0] last_cnt_lp = cnt_w_lp'(width_p - 1);

    if (width_p < 1 || width_p > max_width_lp) begin : g_bad_width
        $error("serial_add_ctrl: width_p out of range");
    end

    state_e              state_q;
    state_e              state_n;
    logic [width_p-1:0]  a_q;
    logic [width_p-1:0]  b_q;
    logic [width_p-1:0]  sum_q;
    logic [width_p-1:0]  sum_n;
    logic                c_q;
    logic [cnt_w_lp-1:0] cnt_q;
    logic                fa_s;
    logic                fa_c;
    logic                accept;
    logic                last_bit;

    full_add u_fa (
        .a_i (a_q[0]),
        .b_i (b_q[0]),
        .c_i (c_q),
        .s_o (fa_s),
        .c_o (fa_c)
    );

    assign ready_o  = (state_q == IDLE_S) && !reset_i;
    assign valid_o  = (state_q == DONE_S);
    assign accept   = valid_i && ready_o;
    assign last_bit = (cnt_q == last_cnt_lp);
    assign sum_o    = sum_q;
    assign carry_o  = c_q;

    always_comb begin
        state_n = state_q;
        case (state_q)
            IDLE_S:  if (accept)   state_n = BUSY_S;
            BUSY_S:  if (last_bit) state_n = DONE_S;
            DONE_S:  if (ready_i)  state_n = IDLE_S;
            default:               state_n = IDLE_S;
        endcase
    end

    // New sum bits enter at the MSB so the LSB lands at bit 0 after width_p shifts.
    always_comb begin
        sum_n              = sum_q >> 1;
        sum_n[width_p-1]   = fa_s;
    end

    always_ff @(posedge clk_i) begin
        if (reset_i) begin
            state_q <= IDLE_S;
            a_q     <= '0;
            b_q     <= '0;
            sum_q   <= '0;
            c_q     <= 1'b0;
            cnt_q   <= '0;
        end else begin
            state_q <= state_n;
            if (accept) begin
                a_q   <= a_i;
                b_q   <= b_i;
                c_q   <= 1'b0;
                cnt_q <= '0;
            end else if (state_q == BUSY_S) begin
                a_q   <= a_q >> 1;
                b_q   <= b_q >> 1;
                sum_q <= sum_n;
                c_q   <= fa_c;
                cnt_q <= cnt_q + cnt_w_lp'(1);
            end
        end
    end

`ifdef SERIAL_ADD_OVERFLOW_EN
    logic ovf_q;

    // On the last bit c_q is the carry into the MSB and fa_c the carry out of it.
    always_ff @(posedge clk_i) begin
        if (reset_i) begin
            ovf_q <= 1'b0;
        end else if (state_q == BUSY_S && last_bit) begin
            ovf_q <= c_q ^ fa_c;
        end
    end

    assign overflow_o = ovf_q;
`endif

    a_state_legal: assert property (@(posedge clk_i) disable iff (reset_i)
        state_q inside {IDLE_S, BUSY_S, DONE_S});

    a_no_valid_and_ready: assert property (@(posedge clk_i) disable iff (reset_i)
        !(valid_o && ready_o));

    a_result_stable: assert property (@(posedge clk_i) disable iff (reset_i)
        (valid_o && !ready_i) |=> ($stable(sum_o) && $stable(carry_o)));

endmodule

// File: tb/tb_serial_add_ctrl.sv
// Randomized self-checking bench for serial_add_ctrl at width_p=4 and width_p=1.
// Expected results come from plain integer addition of the operands.
module tb_serial_add_ctrl;

    logic       clk = 1'b0;
    logic       reset_i;

    logic       valid4;
    logic       ready4;
    logic [3:0] a4;
    logic [3:0] b4;
    logic       vout4;
    logic       rin4;
    logic [3:0] sum4;
    logic       carry4;

    logic       valid1;
    logic       ready1;
    logic [0:0] a1;
    logic [0:0] b1;
    logic       vout1;
    logic       rin1;
    logic [0:0] sum1;
    logic       carry1;

`ifdef SERIAL_ADD_OVERFLOW_EN
    logic       ovf4;
    logic       ovf1;
`endif

    int n_checks = 0;
    int n_errors = 0;

    always #5 clk = ~clk;

    serial_add_ctrl #(.width_p(4)) u_dut4 (
        .clk_i      (clk),
        .reset_i    (reset_i),
        .valid_i    (valid4),
        .ready_o    (ready4),
        .a_i        (a4),
        .b_i        (b4),
        .valid_o    (vout4),
        .ready_i    (rin4),
        .sum_o      (sum4),
`ifdef SERIAL_ADD_OVERFLOW_EN
        .overflow_o (ovf4),
`endif
        .carry_o    (carry4)
    );

    serial_add_ctrl #(.width_p(1)) u_dut1 (
        .clk_i      (clk),
        .reset_i    (reset_i),
        .valid_i    (valid1),
        .ready_o    (ready1),
        .a_i        (a1),
        .b_i        (b1),
        .valid_o    (vout1),
        .ready_i    (rin1),
        .sum_o      (sum1),
`ifdef SERIAL_ADD_OVERFLOW_EN
        .overflow_o (ovf1),
`endif
        .carry_o    (carry1)
    );

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_checks++;
        if (obs !== exp) begin
            n_errors++;
            $display("FAIL %s: got %0h expected %0h at %0t", tag, obs, exp, $time);
        end
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    // One width-4 operation: accept, measure latency, check result, hold for
    // `hold` cycles with ready_i low while poking ignored operands, then consume.
    task automatic do_op4(input logic [3:0] a, input logic [3:0] b, input int hold);
        int         cnt;
        int         sa;
        int         sb;
        int         ssum;
        logic [4:0] exp;
        logic [3:0] sum_seen;
        logic       carry_seen;

        exp = {1'b0, a} + {1'b0, b};
        sa  = (a >= 8) ? int'(a) - 16 : int'(a);
        sb  = (b >= 8) ? int'(b) - 16 : int'(b);
        ssum = sa + sb;

        cnt = 0;
        while (!ready4 && cnt < 20) begin
            tick();
            cnt++;
        end
        check("ready_wait", 32'(ready4), 32'd1);

        valid4 = 1'b1;
        a4     = a;
        b4     = b;
        cnt    = 0;
        do begin
            tick();
            cnt++;
            valid4 = 1'(cnt > 1 && $urandom_range(0, 1) == 1);
            a4     = 4'($urandom);
            b4     = 4'($urandom);
        end while (!vout4 && cnt < 20);
        valid4 = 1'b0;

        check("latency", 32'(cnt), 32'd5);
        check("sum", 32'(sum4), 32'(exp[3:0]));
        check("carry", 32'(carry4), 32'(exp[4]));
        check("ready_in_done", 32'(ready4), 32'd0);
`ifdef SERIAL_ADD_OVERFLOW_EN
        check("overflow", 32'(ovf4), 32'(ssum > 7 || ssum < -8));
`endif
        sum_seen   = sum4;
        carry_seen = carry4;

        for (int i = 0; i < hold; i++) begin
            valid4 = 1'($urandom_range(0, 1));
            a4     = 4'($urandom);
            b4     = 4'($urandom);
            tick();
            check("hold_valid", 32'(vout4), 32'd1);
            check("hold_ready", 32'(ready4), 32'd0);
            check("hold_sum", 32'(sum4), 32'(sum_seen));
            check("hold_carry", 32'(carry4), 32'(carry_seen));
        end
        valid4 = 1'b0;

        rin4 = 1'b1;
        tick();
        rin4 = 1'b0;
        check("consume_valid", 32'(vout4), 32'd0);
        check("consume_ready", 32'(ready4), 32'd1);
    endtask

    initial begin
        int         err_before;
        int         cnt;
        logic [1:0] exp1;

        reset_i = 1'b1;
        valid4  = 1'b0;
        rin4    = 1'b0;
        a4      = '0;
        b4      = '0;
        valid1  = 1'b0;
        rin1    = 1'b0;
        a1      = '0;
        b1      = '0;

        tick();
        tick();
        check("rst_ready", 32'(ready4), 32'd0);
        check("rst_valid", 32'(vout4), 32'd0);
        check("rst_sum", 32'(sum4), 32'd0);
        check("rst_carry", 32'(carry4), 32'd0);
        check("rst_ready_w1", 32'(ready1), 32'd0);
        reset_i = 1'b0;
        #1;
        check("idle_ready", 32'(ready4), 32'd1);
        check("idle_valid", 32'(vout4), 32'd0);

        do_op4(4'd3, 4'd5, 0);
        do_op4(4'd15, 4'd1, 0);
        do_op4(4'd7, 4'd1, 0);
        do_op4(4'd9, 4'd6, 10);

        // Abort an operation in its second BUSY cycle.
        valid4 = 1'b1;
        a4     = 4'd10;
        b4     = 4'd10;
        tick();
        valid4 = 1'b0;
        tick();
        reset_i = 1'b1;
        tick();
        reset_i = 1'b0;
        #1;
        check("abort_ready", 32'(ready4), 32'd1);
        check("abort_valid", 32'(vout4), 32'd0);
        check("abort_sum", 32'(sum4), 32'd0);
        do_op4(4'd1, 4'd2, 0);

        for (int a = 0; a < 16; a++) begin
            for (int b = 0; b < 16; b++) begin
                err_before = n_errors;
                do_op4(4'(a), 4'(b), 0);
                $display("sweep a=%0d b=%0d -> %s", a, b,
                         (n_errors == err_before) ? "ok" : "bad");
            end
        end

        for (int k = 0; k < 30; k++) begin
            do_op4(4'($urandom), 4'($urandom), int'($urandom_range(0, 4)));
        end

        for (int i = 0; i < 4; i++) begin
            a1   = 1'(i >> 1);
            b1   = 1'(i);
            exp1 = {1'b0, a1} + {1'b0, b1};
            cnt  = 0;
            while (!ready1 && cnt < 10) begin
                tick();
                cnt++;
            end
            valid1 = 1'b1;
            cnt    = 0;
            do begin
                tick();
                cnt++;
                valid1 = 1'b0;
            end while (!vout1 && cnt < 10);
            check("w1_latency", 32'(cnt), 32'd2);
            check("w1_result", 32'({carry1, sum1}), 32'(exp1));
            rin1 = 1'b1;
            tick();
            rin1 = 1'b0;
            check("w1_consume", 32'(vout1), 32'd0);
        end

        $display("CHECKS %0d ERRORS %0d", n_checks, n_errors);
        $finish;
    end

    initial begin
        #2000000;
        $display("FAIL timeout: simulation did not finish");
        $fatal(1);
    end

endmodule
